// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// RW_* encodings are also used by the data memory and the RAM_CTRL decode.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] FETCH_SIZE = 2'b10;
  localparam logic       RW_READ    = 1'b0;
  localparam logic       RW_WRITE   = 1'b1;

  // Enough for MEM_LAT up to 15.
  localparam int CNT_W = 4;

  // Width of a counter that must reach lim; never narrower than one bit.
  function automatic int starve_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner select for the shared memory port: data normally wins a tie,
// fetch wins once the starvation counter has reached its limit.
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter  int STARVE_LIM = 4,
  localparam int SW         = starve_w(STARVE_LIM)
) (
  input  logic          if_elig_i,
  input  logic          d_elig_i,
  input  logic [SW-1:0] starve_cnt_i,
  output logic          grant_if_o,
  output logic          grant_d_o
);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic starved;

  assign starved = (starve_cnt_i == STARVE_MAX);

  always_comb begin
    grant_if_o = 1'b0;
    grant_d_o  = 1'b0;
    if (if_elig_i && d_elig_i) begin
      grant_if_o = starved;
      grant_d_o  = ~starved;
    end else begin
      grant_if_o = if_elig_i;
      grant_d_o  = d_elig_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage data access onto one
// single-ported memory with fixed-latency transactions and ready pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int                SW         = starve_w(STARVE_LIM);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIM);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ready_q, d_ready_d;

  logic if_elig, d_elig;
  logic grant_if, grant_d;
  logic done, arb_now;

  // A requester acknowledged this cycle must not be re-granted before it drops.
  assign if_elig = if_req & ~if_ready_q;
  assign d_elig  = d_req  & ~d_ready_q;

  assign done    = (state_q != ARB_IDLE) && (cnt_q == '0);
  assign arb_now = (state_q == ARB_IDLE) || done;

  arb_priority #(
    .STARVE_LIM (STARVE_LIM)
  ) u_arb_priority (
    .if_elig_i    (if_elig),
    .d_elig_i     (d_elig),
    .starve_cnt_i (starve_q),
    .grant_if_o   (grant_if),
    .grant_d_o    (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    if ((state_q != ARB_IDLE) && !done) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (done) begin
      if (state_q == ARB_BUSY_I) begin
        if_rdata_d = mem_rdata;
        if_ready_d = 1'b1;
      end else begin
        if (mem_rw_q == RW_READ) begin
          d_rdata_d = mem_rdata;
        end
        d_ready_d = 1'b1;
      end
    end

    // Completion and the next grant share an edge, keeping mem_en high back-to-back.
    if (arb_now) begin
      if (grant_if) begin
        state_d     = ARB_BUSY_I;
        cnt_d       = CNT_LOAD;
        starve_d    = '0;
        mem_en_d    = 1'b1;
        mem_rw_d    = RW_READ;
        mem_size_d  = FETCH_SIZE;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end else if (grant_d) begin
        state_d     = ARB_BUSY_D;
        cnt_d       = CNT_LOAD;
        mem_en_d    = 1'b1;
        mem_rw_d    = d_rw;
        mem_size_d  = d_size;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
        if (if_elig && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        state_d  = ARB_IDLE;
        mem_en_d = 1'b0;
        mem_rw_d = RW_READ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req = 1'b0;
  logic              d_rw = 1'b0;
  logic [1:0]        d_size = 2'b00;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Environment memory, loaded through a backdoor port while reset is held.
  logic [DATA_W-1:0] mem [256];
  logic              bd_we = 1'b0;
  logic [7:0]        bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && mem_rw) mem[mem_addr] <= mem_wdata;
  end

  // Reference model: current owner (0 none, 1 fetch, 2 data) and the edge it finishes on.
  logic [DATA_W-1:0] rm [256];
  int                m_owner, m_done, edge_no, m_starve;
  logic              m_ir, m_dr;
  logic [DATA_W-1:0] m_ird, m_drd;
  logic [7:0]        m_addr;
  logic              m_rw;
  logic [1:0]        m_size;
  logic [DATA_W-1:0] m_wdata;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = 0; m_done = 0; edge_no = 0; m_starve = 0;
    m_ir = 1'b0; m_dr = 1'b0; m_ird = '0; m_drd = '0;
    m_addr = '0; m_rw = 1'b0; m_size = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    logic ie, de, nir, ndr;
    int   win;
    ie  = if_req & ~m_ir;
    de  = d_req & ~m_dr;
    nir = 1'b0;
    ndr = 1'b0;
    if (m_owner == 0 || edge_no == m_done) begin
      if (m_owner == 1) begin
        nir = 1'b1; m_ird = rm[m_addr];
      end else if (m_owner == 2) begin
        ndr = 1'b1;
        if (m_rw) rm[m_addr] = m_wdata;
        else m_drd = rm[m_addr];
      end
      win = 0;
      if (ie && de) win = (m_starve == STARVE_LIM) ? 1 : 2;
      else if (de) win = 2;
      else if (ie) win = 1;
      if (win == 1) begin
        m_starve = 0; m_addr = if_addr; m_rw = 1'b0; m_size = 2'b10; m_wdata = '0;
      end else if (win == 2) begin
        if (ie && m_starve < STARVE_LIM) m_starve++;
        m_addr = d_addr; m_rw = d_rw; m_size = d_size; m_wdata = d_wdata;
      end
      m_owner = win;
      m_done  = edge_no + MEM_LAT;
    end
    m_ir = nir;
    m_dr = ndr;
    edge_no++;
  endtask

  task automatic check_outputs();
    chk("mem_en", 64'(mem_en), 64'(m_owner != 0));
    if (m_owner != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_rw", 64'(mem_rw), 64'(m_rw));
      chk("mem_size", 64'(mem_size), 64'(m_size));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    chk("if_ready", 64'(if_ready), 64'(m_ir));
    chk("d_ready", 64'(d_ready), 64'(m_dr));
    chk("if_rdata", 64'(if_rdata), 64'(m_ird));
    chk("d_rdata", 64'(d_rdata), 64'(m_drd));
    chk("stall_if", 64'(stall_if), 64'(if_req & ~m_ir));
    chk("stall_mem", 64'(stall_mem), 64'(d_req & ~m_dr));
    chk("starve_cnt", 64'(dut.starve_q), 64'(m_starve));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drain();
    repeat (2 * MEM_LAT + 2) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    int         ns;
    int         n;

    // Fill memory while reset is held low.
    bd_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bd_addr = 8'(a);
      if (a == 8'h10) bd_data = 32'hDEADBEEF;
      else if (a == 8'h30) bd_data = 32'h12345678;
      else bd_data = $urandom;
      rm[a] = bd_data;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;

    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_rw", 64'(mem_rw), 64'd0);
    chk("rst_mem_size", 64'(mem_size), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_stall_if", 64'(stall_if), 64'd0);

    model_reset();
    reset = 1'b1;
    cycle();

    // Single fetch, request held until its ready pulse.
    if_req = 1'b1; if_addr = 8'h10;
    cycle();
    chk("fetch_en", 64'(mem_en), 64'd1);
    chk("fetch_addr", 64'(mem_addr), 64'h10);
    chk("fetch_rw", 64'(mem_rw), 64'd0);
    chk("fetch_stall", 64'(stall_if), 64'd1);
    repeat (MEM_LAT - 1) cycle();
    chk("fetch_en_last", 64'(mem_en), 64'd1);
    chk("fetch_not_ready", 64'(if_ready), 64'd0);
    cycle();
    chk("fetch_ready", 64'(if_ready), 64'd1);
    chk("fetch_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("fetch_stall_pulse", 64'(stall_if), 64'd0);
    if_req = 1'b0;
    drain();

    // Simultaneous requests: data first, then fetch back-to-back.
    d_req = 1'b1; d_rw = 1'b0; d_addr = 8'h20; d_size = 2'b10;
    if_req = 1'b1; if_addr = 8'h84;
    cycle();
    chk("both_first_addr", 64'(mem_addr), 64'h20);
    d_req = 1'b0;
    repeat (MEM_LAT) cycle();
    chk("both_d_ready", 64'(d_ready), 64'd1);
    chk("both_d_rdata", 64'(d_rdata), 64'(rm[8'h20]));
    chk("both_b2b_en", 64'(mem_en), 64'd1);
    chk("both_b2b_addr", 64'(mem_addr), 64'h84);
    repeat (MEM_LAT) cycle();
    chk("both_if_ready", 64'(if_ready), 64'd1);
    chk("both_if_rdata", 64'(if_rdata), 64'(rm[8'h84]));
    if_req = 1'b0;
    drain();

    // Load a known value, then a byte-half write that must leave d_rdata alone.
    d_req = 1'b1; d_rw = 1'b0; d_addr = 8'h30; d_size = 2'b10;
    cycle();
    d_req = 1'b0;
    repeat (MEM_LAT) cycle();
    chk("ld_ready", 64'(d_ready), 64'd1);
    chk("ld_rdata", 64'(d_rdata), 64'h12345678);
    cycle();
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b01; d_addr = 8'h08; d_wdata = 32'h000000AB;
    cycle();
    chk("st_rw", 64'(mem_rw), 64'd1);
    chk("st_size", 64'(mem_size), 64'd1);
    chk("st_wdata", 64'(mem_wdata), 64'hAB);
    chk("st_addr", 64'(mem_addr), 64'h08);
    d_req = 1'b0;
    repeat (MEM_LAT) cycle();
    chk("st_ready", 64'(d_ready), 64'd1);
    chk("st_rdata_kept", 64'(d_rdata), 64'h12345678);
    drain();

    // Both held: four data grants, then one forced fetch, repeating.
    d_req = 1'b1; d_rw = 1'b0; d_addr = 8'h40; d_size = 2'b10;
    if_req = 1'b1; if_addr = 8'h88;
    seq = '0; ns = 0;
    for (int c = 0; c < 120 && ns < 10; c++) begin
      cycle();
      if (d_ready === 1'b1) begin seq[ns] = 1'b0; ns++; end
      else if (if_ready === 1'b1) begin seq[ns] = 1'b1; ns++; end
    end
    chk("starve_count", 64'(ns), 64'd10);
    chk("starve_pattern", 64'(seq), 64'h210);
    d_req = 1'b0; if_req = 1'b0;
    drain();

    // Reset in the middle of a data write.
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 8'h08; d_wdata = 32'h55;
    cycle();
    chk("abort_granted", 64'(mem_en), 64'd1);
    d_req = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    chk("abort_d_ready", 64'(d_ready), 64'd0);
    chk("abort_starve", 64'(dut.starve_q), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) cycle();
    if_req = 1'b1; if_addr = 8'h04;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n++;
      if (if_ready === 1'b1) break;
    end
    chk("post_rst_latency", 64'(n), 64'(MEM_LAT + 1));
    chk("post_rst_rdata", 64'(if_rdata), 64'(rm[8'h04]));
    if_req = 1'b0;
    drain();

    // Random traffic: fetch in upper half, data in lower half of the address space.
    for (int c = 0; c < 800; c++) begin
      if (if_ready) if_req = ($urandom_range(0, 3) == 0);
      else if (if_req) begin
        if ($urandom_range(0, 9) == 0) if_req = 1'b0;
      end else if_req = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 4) == 0) if_addr = 8'($urandom_range(128, 255));

      if (d_ready) d_req = ($urandom_range(0, 3) == 0);
      else if (d_req) begin
        if ($urandom_range(0, 9) == 0) d_req = 1'b0;
      end else d_req = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 3) == 0) begin
        d_addr  = 8'($urandom_range(0, 127));
        d_rw    = 1'($urandom_range(0, 1));
        d_size  = 2'($urandom_range(0, 3));
        d_wdata = $urandom;
      end
      cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
